// File: rtl/instr_fetch_queue_pkg.sv
// Shared definitions for the instruction fetch stage: FSM encoding,
// instruction width and the fetch entry record handed to decode.
package instr_fetch_queue_pkg;

  localparam int INSTR_W = 32;

  // Fetch FSM state encoding
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_WAIT  = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  // One queued instruction together with the address it was fetched from
  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [31:0]        pc;
  } fetch_entry_t;

  // Force a fetch address onto a word boundary
  function automatic logic [31:0] align_pc(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/instr_fetch_queue_fetch_fifo.sv
// Small register-based FIFO of fetch entries with a synchronous flush.
// The head entry is presented directly from the storage registers and is
// forced to zero while the FIFO is empty so decode never sees stale data.
module instr_fetch_queue_fetch_fifo
  import instr_fetch_queue_pkg::*;
#(
  parameter int  DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               flush,
  input  logic               push,
  input  fetch_entry_t       push_entry,
  input  logic               pop,
  output fetch_entry_t       head_entry,
  output logic [CNT_W-1:0]   count
);

  fetch_entry_t       mem_q [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               wr_en;
  logic               pop_ok;

  // A pop on an empty FIFO is ignored rather than corrupting the count
  assign pop_ok = pop && (count_q != '0);

  // Next-state for pointers and occupancy; flush wins over push/pop
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    wr_en    = 1'b0;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        wr_en    = 1'b1;
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (pop_ok) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      if (push && !pop_ok) begin
        count_d = count_q + CNT_W'(1);
      end else if (!push && pop_ok) begin
        count_d = count_q - CNT_W'(1);
      end
    end
  end

  // Pointer and occupancy registers
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage; contents need no reset because count gates visibility
  always_ff @(posedge clock) begin
    if (wr_en) begin
      mem_q[wr_ptr_q] <= push_entry;
    end
  end

  assign head_entry = (count_q != '0) ? mem_q[rd_ptr_q] : '0;
  assign count      = count_q;

endmodule

// File: rtl/instr_fetch_queue.sv
// Fetch stage: owns the PC, issues one word fetch at a time to instruction
// memory, queues the returned instructions and hands them to decode with a
// valid/ready handshake. A redirect flushes the queue and drops whatever
// response is still in flight.
module instr_fetch_queue
  import instr_fetch_queue_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  localparam int         CNT_W    = $clog2(DEPTH) + 1
) (
  input  logic               clock,
  input  logic               reset,
  output logic               imem_req_valid,
  output logic [31:0]        imem_req_addr,
  input  logic               imem_resp_valid,
  input  logic [INSTR_W-1:0] imem_resp_data,
  input  logic               redirect_valid,
  input  logic [31:0]        redirect_pc,
  input  logic               deq_ready,
  output logic               deq_valid,
  output logic [INSTR_W-1:0] deq_instr,
  output logic [31:0]        deq_pc,
  output logic [CNT_W-1:0]   count
);

  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [1:0]   state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic         req_fire;
  logic         push_en;
  logic         pop_en;
  logic         have_credit;
  fetch_entry_t push_entry;
  fetch_entry_t head_entry;

  // Only ask for a word when the queue is guaranteed to have room for it
  assign have_credit = (count < FULL_CNT);

  // Fetch FSM: request from IDLE, collect in WAIT, swallow a dropped reply in DRAIN
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    req_fire = 1'b0;
    push_en  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!redirect_valid && have_credit) begin
          req_fire = 1'b1;
          state_d  = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (imem_resp_valid) begin
          if (!redirect_valid) begin
            push_en = 1'b1;
            pc_d    = pc_q + 32'd4;
          end
          state_d = ST_IDLE;
        end else if (redirect_valid) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (imem_resp_valid) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    // A redirect always retargets the PC, whatever the FSM is doing
    if (redirect_valid) begin
      pc_d = align_pc(redirect_pc);
    end
  end

  // FSM and PC registers
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
      pc_q    <= align_pc(RESET_PC);
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  assign push_entry.instr = imem_resp_data;
  assign push_entry.pc    = pc_q;
  assign pop_en           = deq_valid && deq_ready;

  instr_fetch_queue_fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fetch_fifo (
    .clock      (clock),
    .reset      (reset),
    .flush      (redirect_valid),
    .push       (push_en),
    .push_entry (push_entry),
    .pop        (pop_en),
    .head_entry (head_entry),
    .count      (count)
  );

  // The request strobe is combinational from FSM state, so hold it off in reset
  assign imem_req_valid = req_fire & ~reset;
  assign imem_req_addr  = pc_q;
  assign deq_valid      = (count != '0);
  assign deq_instr      = head_entry.instr;
  assign deq_pc         = head_entry.pc;

endmodule
